uart_rx_deser: RTL and testbench

- UART receive deserializer, 8N1 framing, 16x oversampling.
- Sits directly upstream of the 32x8 receive FIFO.
- RX_DATA drives FIFO_WR_DATA and RX_VALID drives FIFO_WREN.
- Consumes FIFO_FULL so that a byte which cannot be stored is reported as an overrun instead of being silently dropped.

---
 rtl/uart_rx_deser.sv | 144 ++++++++++++++
 tb/tb_uart_rx_deser.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deser.sv
// UART 8N1 receive deserializer with 16x oversampling, feeding a downstream RX FIFO.
// Reports frame errors and FIFO-full overruns as single-cycle pulses.
module uart_rx_deser #(
  parameter int unsigned OvsDiv     = 27,
  parameter int unsigned SyncStages = 2
) (
  input  logic       sclk_i,
  input  logic       rst_i,
  input  logic       uart_rxd_i,
  input  logic       fifo_full_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       frame_err_o,
  output logic       rx_overrun_o,
  output logic       rx_busy_o
);

  localparam int unsigned PreW = (OvsDiv > 1) ? $clog2(OvsDiv) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e                state_q, state_d;
  logic [SyncStages-1:0] sync_q;
  logic                  rxd_d_q;
  logic [PreW-1:0]       pre_q, pre_d;
  logic [3:0]            idx_q, idx_d;
  logic [3:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic [7:0]            data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;

  logic rxd_s, fall, tick, sample, counting;

  assign rxd_s    = sync_q[SyncStages-1];
  assign fall     = rxd_d_q & ~rxd_s;
  assign counting = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
  assign tick     = counting && (pre_q == PreW'(OvsDiv - 1));
  // Index 7 is mid-bit: half a bit after the start edge, then every 16 ticks.
  assign sample   = tick && (idx_q == 4'd7);

  always_ff @(posedge sclk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '1;
      rxd_d_q <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SyncStages-2:0], uart_rxd_i};
      rxd_d_q <= rxd_s;
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = '0;
    idx_d   = '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (counting) begin
      pre_d = tick ? '0 : pre_q + PreW'(1);
      idx_d = tick ? idx_q + 4'd1 : idx_q;
    end

    unique case (state_q)
      StIdle: begin
        bit_d = '0;
        if (fall) state_d = StStart;
      end
      StStart: begin
        if (sample) begin
          if (!rxd_s) begin
            state_d = StData;
            bit_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (sample) begin
          shift_d = {rxd_s, shift_q[7:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (sample) begin
          if (rxd_s) begin
            state_d = StIdle;
            if (fifo_full_i) begin
              ovr_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end
      end
      StBreak: begin
        if (rxd_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      pre_q   <= '0;
      idx_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data_o    = data_q;
  assign rx_valid_o   = valid_q;
  assign frame_err_o  = ferr_q;
  assign rx_overrun_o = ovr_q;
  assign rx_busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser: directed frames plus randomized traffic
// scored against a frame-level model of expected pulses, data and latency.
module tb_uart_rx_deser;

  localparam int unsigned Ovs    = 4;
  localparam int          BitClk = 16 * Ovs;
  localparam int          LatNom = 2 + 1 + (19 * BitClk) / 2;

  localparam logic [2:0] KValid = 3'b100;
  localparam logic [2:0] KFerr  = 3'b010;
  localparam logic [2:0] KOvr   = 3'b001;

  logic       clk, rst, rxd, full;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, rx_overrun, rx_busy;

  uart_rx_deser #(
    .OvsDiv     (Ovs),
    .SyncStages (2)
  ) u_dut (
    .sclk_i       (clk),
    .rst_i        (rst),
    .uart_rxd_i   (rxd),
    .fifo_full_i  (full),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .frame_err_o  (frame_err),
    .rx_overrun_o (rx_overrun),
    .rx_busy_o    (rx_busy)
  );

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t        ev_q[$];
  ev_t        mon_e;
  int         cyc;
  int         n_vec;
  int         n_err;
  logic [7:0] exp_data;
  int         last_pulse;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Every pulse cycle becomes an event; a stretched or doubled pulse shows up as extra events.
  always @(negedge clk) begin
    if (rx_valid || frame_err || rx_overrun) begin
      mon_e.kind = {rx_valid, frame_err, rx_overrun};
      mon_e.data = rx_data;
      mon_e.cyc  = cyc;
      ev_q.push_back(mon_e);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // kind: 0 = good stop, FIFO free; 1 = good stop, FIFO full; 2 = stop low for brk_len clk.
  task automatic send_frame(input logic [7:0] b, input int kind, input int brk_len,
                            input bit rand_full);
    int         t0;
    int         lat;
    logic [2:0] exp_kind;
    ev_t        e;
    rxd = 1'b0;
    t0  = cyc;
    hold(BitClk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      full = rand_full ? 1'($urandom_range(0, 1)) : 1'b0;
      if (i == 0) check_eq($sformatf("busy_mid_%02h", b), {31'd0, rx_busy}, 32'd1);
      hold(BitClk);
    end
    full = (kind == 1);
    if (kind == 2) begin
      rxd = 1'b0;
      hold(brk_len);
      rxd = 1'b1;
      hold(BitClk);
    end else begin
      rxd = 1'b1;
      hold(BitClk);
    end
    full = 1'b0;

    case (kind)
      0:       begin exp_kind = KValid; exp_data = b; end
      1:       exp_kind = KOvr;
      default: exp_kind = KFerr;
    endcase

    check_eq($sformatf("n_events_%02h_k%0d", b, kind), ev_q.size(), 32'd1);
    if (ev_q.size() > 0) begin
      e   = ev_q.pop_front();
      lat = e.cyc - t0;
      check_eq($sformatf("pulse_kind_%02h", b), {29'd0, e.kind}, {29'd0, exp_kind});
      check_eq($sformatf("pulse_data_%02h", b), {24'd0, e.data}, {24'd0, exp_data});
      check_eq($sformatf("latency_%0d_in_range", lat),
               {31'd0, (lat >= LatNom - 1) && (lat <= LatNom + 1)}, 32'd1);
      last_pulse = e.cyc;
    end
    ev_q.delete();
    check_eq($sformatf("data_after_%02h", b), {24'd0, rx_data}, {24'd0, exp_data});
    check_eq($sformatf("busy_end_%02h", b), {31'd0, rx_busy}, 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_data"}, {24'd0, rx_data}, {24'd0, exp_data});
    check_eq({tag, "_pulses"}, {29'd0, rx_valid, frame_err, rx_overrun}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, rx_busy}, 32'd0);
  endtask

  initial begin
    int p0;
    int kind;
    n_vec      = 0;
    n_err      = 0;
    exp_data   = 8'h00;
    last_pulse = 0;
    rst  = 1'b1;
    rxd  = 1'b1;
    full = 1'b0;
    hold(5);
    check_idle_outputs("reset");
    rst = 1'b0;
    hold(20);

    send_frame(8'hA5, 0, 0, 1'b0);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 0, 0, 1'b0);
    p0 = last_pulse;
    send_frame(8'hFF, 0, 0, 1'b0);
    check_eq("b2b_spacing_1", last_pulse - p0, BitClk * 10);
    p0 = last_pulse;
    send_frame(8'h3C, 0, 0, 1'b0);
    check_eq("b2b_spacing_2", last_pulse - p0, BitClk * 10);

    // Start glitch shorter than half a bit.
    hold(40);
    rxd = 1'b0;
    hold(16);
    check_eq("glitch_busy_hi", {31'd0, rx_busy}, 32'd1);
    rxd = 1'b1;
    hold(24);
    check_eq("glitch_busy_lo", {31'd0, rx_busy}, 32'd0);
    hold(200);
    check_eq("glitch_no_pulse", ev_q.size(), 32'd0);
    ev_q.delete();

    send_frame(8'h3C, 2, 2000, 1'b0);
    send_frame(8'h5A, 0, 0, 1'b0);
    send_frame(8'h81, 1, 0, 1'b0);
    send_frame(8'h81, 0, 0, 1'b0);

    // Reset in the middle of data bit 4 of 0xF0.
    rxd = 1'b0;
    hold(BitClk);
    for (int i = 0; i < 4; i++) begin
      rxd = 1'b0;
      hold(BitClk);
    end
    rxd = 1'b1;
    hold(BitClk / 2);
    rst = 1'b1;
    #1;
    exp_data = 8'h00;
    check_idle_outputs("mid_reset");
    hold(10);
    rxd = 1'b1;
    hold(10);
    rst = 1'b0;
    hold(700);
    check_eq("reset_no_pulse", ev_q.size(), 32'd0);
    ev_q.delete();
    send_frame(8'h12, 0, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 9);
      kind = (kind < 7) ? 0 : (kind < 9) ? 1 : 2;
      send_frame(8'($urandom_range(0, 255)), kind, $urandom_range(100, 400), 1'b1);
      hold($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 100));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
